// File: rtl/dm_arbiter_if.sv
// Bus bundle between the two memory requesters, the data-memory arbiter and the data memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dm_arbiter_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [31:0]       m0_wdata;
    logic              m0_ack;
    logic [31:0]       m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [31:0]       m1_wdata;
    logic              m1_ack;
    logic [31:0]       m1_rdata;
    logic              m1_lock;

    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_din;
    logic              dm_we;
    logic [31:0]       dm_dout;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        output m1_ack, m1_rdata,
        output dm_addr, dm_din, dm_we,
        input  dm_dout
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        input  m1_ack, m1_rdata,
        input  dm_addr, dm_din, dm_we,
        output dm_dout
    );
endinterface

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between the CPU (port 0) and a
// DMA/debug loader (port 1), with a bounded burst lock for port 1.
module dm_arbiter #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned MAX_LOCK = 4
) (
    input logic         clk_i,
    input logic         rst_ni,
    dm_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    localparam logic [3:0] MaxLockCnt = 4'(MAX_LOCK);

    state_e            state_q;
    logic              gnt_q;
    logic              last_gnt_q;
    logic [3:0]        lock_cnt_q;
    logic              m0_ack_q;
    logic              m1_ack_q;
    logic [31:0]       m0_rdata_q;
    logic [31:0]       m1_rdata_q;
    logic [ADDR_W-1:0] addr_hold_q;
    logic [31:0]       din_hold_q;

    logic              lock_active;
    logic              any_req;
    logic              gnt_d;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic              in_access;

    always_comb begin
        lock_active = last_gnt_q && bus.m1_lock && (lock_cnt_q < MaxLockCnt);
        any_req     = bus.m0_req || bus.m1_req;
        if (bus.m0_req && bus.m1_req) begin
            gnt_d = lock_active ? 1'b1 : ~last_gnt_q;
        end else begin
            gnt_d = bus.m1_req;
        end
        sel_we    = gnt_q ? bus.m1_we    : bus.m0_we;
        sel_addr  = gnt_q ? bus.m1_addr  : bus.m0_addr;
        sel_wdata = gnt_q ? bus.m1_wdata : bus.m0_wdata;
    end

    // Combinational off the state register so an asynchronous reset kills dm_we at once.
    assign in_access    = (state_q == StAccess);
    assign bus.dm_we    = in_access && sel_we;
    assign bus.dm_addr  = in_access ? sel_addr  : addr_hold_q;
    assign bus.dm_din   = in_access ? sel_wdata : din_hold_q;
    assign bus.m0_ack   = m0_ack_q;
    assign bus.m1_ack   = m1_ack_q;
    assign bus.m0_rdata = m0_rdata_q;
    assign bus.m1_rdata = m1_rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            gnt_q       <= 1'b0;
            last_gnt_q  <= 1'b1;
            lock_cnt_q  <= '0;
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            addr_hold_q <= '0;
            din_hold_q  <= '0;
        end else begin
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!bus.m1_lock) begin
                        lock_cnt_q <= '0;
                    end
                    if (any_req) begin
                        state_q <= StAccess;
                        gnt_q   <= gnt_d;
                        if (!gnt_d) begin
                            lock_cnt_q <= '0;
                        end else if (bus.m0_req && bus.m1_lock) begin
                            lock_cnt_q <= lock_cnt_q + 4'd1;
                        end
                    end
                end
                StAccess: begin
                    state_q     <= StResp;
                    last_gnt_q  <= gnt_q;
                    addr_hold_q <= sel_addr;
                    din_hold_q  <= sel_wdata;
                    if (gnt_q) begin
                        m1_ack_q <= 1'b1;
                        if (!sel_we) m1_rdata_q <= bus.dm_dout;
                    end else begin
                        m0_ack_q <= 1'b1;
                        if (!sel_we) m0_rdata_q <= bus.dm_dout;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dm_arbiter.sv
// Randomised bench for dm_arbiter: a slot-level reference model predicts grants, acks,
// memory bus activity and read data, alongside directed reset, read, write and lock scenarios.
module tb_dm_arbiter;
    localparam int unsigned AW      = 10;
    localparam int          MaxLock = 4;

    logic clk;
    logic rst_n;

    dm_arbiter_if #(.ADDR_W(AW)) bus ();

    dm_arbiter #(
        .ADDR_W  (AW),
        .MAX_LOCK(MaxLock)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical memory, driven only by the DUT's memory port.
    logic [31:0] mem [1024];
    assign bus.dm_dout = mem[bus.dm_addr];
    always @(posedge clk) if (bus.dm_we) mem[bus.dm_addr] <= bus.dm_din;

    int n_checks;
    int n_errors;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Requester state
    logic          r_req   [2];
    logic          r_we    [2];
    logic [AW-1:0] r_addr  [2];
    logic [31:0]   r_wdata [2];
    logic          r_lock;

    // Reference model: phase 0 idle, 1 access, 2 response
    logic [31:0] ref_mem [1024];
    logic [31:0] exp_rd  [2];
    int m_phase, m_gnt, m_last, m_cnt;
    int rr_prev, m1_run;
    bit lk_seen;

    task automatic drive();
        bus.m0_req   = r_req[0];
        bus.m0_we    = r_we[0];
        bus.m0_addr  = r_addr[0];
        bus.m0_wdata = r_wdata[0];
        bus.m1_req   = r_req[1];
        bus.m1_we    = r_we[1];
        bus.m1_addr  = r_addr[1];
        bus.m1_wdata = r_wdata[1];
        bus.m1_lock  = r_lock;
    endtask

    task automatic model_reset();
        m_phase   = 0;
        m_gnt     = 0;
        m_last    = 1;
        m_cnt     = 0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
    endtask

    task automatic new_req(input int p);
        r_req[p]   = 1'b1;
        r_we[p]    = 1'($urandom_range(0, 1));
        r_addr[p]  = ($urandom_range(0, 7) == 0) ? AW'(1023) : AW'($urandom_range(0, 15));
        r_wdata[p] = $urandom;
    endtask

    // Slot-level arbitration: port 1 keeps the memory while it holds the lock and has taken
    // fewer than MaxLock contended slots in a row; otherwise contended slots alternate.
    task automatic advance();
        int g;
        if (m_phase == 0) begin
            if (!r_lock) m_cnt = 0;
            if (r_req[0] || r_req[1]) begin
                if (r_req[0] && r_req[1]) begin
                    g = (m_last == 1 && r_lock && m_cnt < MaxLock) ? 1 : 1 - m_last;
                end else begin
                    g = r_req[1] ? 1 : 0;
                end
                if (g == 0) m_cnt = 0;
                else if (r_req[0] && r_lock) m_cnt++;
                m_gnt   = g;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (r_we[m_gnt]) ref_mem[r_addr[m_gnt]] = r_wdata[m_gnt];
            else exp_rd[m_gnt] = ref_mem[r_addr[m_gnt]];
            m_last  = m_gnt;
            m_phase = 2;
        end else begin
            m_phase = 0;
        end
    endtask

    // mode 0: random, 1: both busy without lock, 2: both busy with lock, 3: no new requests
    task automatic step(input int mode);
        logic ack_now [2];
        int   cur;
        advance();
        @(negedge clk);
        ack_now[0] = (m_phase == 2) && (m_gnt == 0);
        ack_now[1] = (m_phase == 2) && (m_gnt == 1);
        check_eq("m0_ack", 32'(bus.m0_ack), 32'(ack_now[0]));
        check_eq("m1_ack", 32'(bus.m1_ack), 32'(ack_now[1]));
        check_eq("m0_rdata", bus.m0_rdata, exp_rd[0]);
        check_eq("m1_rdata", bus.m1_rdata, exp_rd[1]);
        if (m_phase == 1) begin
            check_eq("dm_we", 32'(bus.dm_we), 32'(r_we[m_gnt]));
            check_eq("dm_addr", 32'(bus.dm_addr), 32'(r_addr[m_gnt]));
            if (r_we[m_gnt]) check_eq("dm_din", bus.dm_din, r_wdata[m_gnt]);
        end else begin
            check_eq("dm_we_idle", 32'(bus.dm_we), 32'd0);
        end

        // Grant-order properties taken straight from the DUT acks
        if (mode == 1) begin
            if (bus.m0_ack || bus.m1_ack) begin
                cur = bus.m1_ack ? 1 : 0;
                if (rr_prev >= 0) check_eq("rr_alt", 32'(cur), 32'(1 - rr_prev));
                rr_prev = cur;
            end
        end else begin
            rr_prev = -1;
        end
        if (mode == 2) begin
            if (bus.m1_ack) m1_run++;
            if (bus.m0_ack) begin
                if (lk_seen) check_eq("lock_run", 32'(m1_run), 32'(MaxLock));
                lk_seen = 1'b1;
                m1_run  = 0;
            end
        end else begin
            lk_seen = 1'b0;
            m1_run  = 0;
        end

        for (int p = 0; p < 2; p++) begin
            if (ack_now[p]) begin
                if (mode == 1 || mode == 2 || (mode == 0 && $urandom_range(0, 1) == 1)) new_req(p);
                else r_req[p] = 1'b0;
            end else if (!r_req[p]) begin
                if (mode == 1 || mode == 2 || (mode == 0 && $urandom_range(0, 2) == 0)) new_req(p);
            end
        end
        if (mode == 1) r_lock = 1'b0;
        else if (mode == 2) r_lock = 1'b1;
        else if (mode == 0 && $urandom_range(0, 15) == 0) r_lock = ~r_lock;
        drive();
    endtask

    logic [31:0] old_word;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rr_prev  = -1;
        m1_run   = 0;
        lk_seen  = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            old_word   = $urandom;
            mem[i]     = old_word;
            ref_mem[i] = old_word;
        end
        mem[5]     = 32'hDEADBEEF;
        ref_mem[5] = 32'hDEADBEEF;
        for (int p = 0; p < 2; p++) begin
            r_req[p]   = 1'b0;
            r_we[p]    = 1'b0;
            r_addr[p]  = '0;
            r_wdata[p] = '0;
        end
        r_lock = 1'b0;
        drive();
        model_reset();

        rst_n = 1'b0;
        #12;
        check_eq("rst_m0_ack", 32'(bus.m0_ack), 32'd0);
        check_eq("rst_m1_ack", 32'(bus.m1_ack), 32'd0);
        check_eq("rst_m0_rdata", bus.m0_rdata, 32'd0);
        check_eq("rst_m1_rdata", bus.m1_rdata, 32'd0);
        check_eq("rst_dm_we", 32'(bus.dm_we), 32'd0);
        check_eq("rst_dm_addr", 32'(bus.dm_addr), 32'd0);
        check_eq("rst_dm_din", bus.dm_din, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single read on port 0
        r_req[0] = 1'b1; r_we[0] = 1'b0; r_addr[0] = AW'(5);
        drive();
        repeat (3) step(3);
        check_eq("single_read", bus.m0_rdata, 32'hDEADBEEF);

        // Write through port 0, read back through port 1
        r_req[0] = 1'b1; r_we[0] = 1'b1; r_addr[0] = AW'(1023); r_wdata[0] = 32'h12345678;
        drive();
        repeat (3) step(3);
        r_req[1] = 1'b1; r_we[1] = 1'b0; r_addr[1] = AW'(1023);
        drive();
        repeat (3) step(3);
        check_eq("readback", bus.m1_rdata, 32'h12345678);

        // Contended round-robin, then locked bursts, then drain
        repeat (18) step(1);
        repeat (45) step(2);
        repeat (9) step(3);

        // Long idle, then a late request
        repeat (20) step(3);
        r_req[0] = 1'b1; r_we[0] = 1'b0; r_addr[0] = AW'(7);
        drive();
        repeat (3) step(3);

        // Reset in the middle of a port-1 write
        old_word = ref_mem[16];
        r_req[1] = 1'b1; r_we[1] = 1'b1; r_addr[1] = AW'(16); r_wdata[1] = 32'hAAAA5555;
        r_lock = 1'b0;
        drive();
        step(3);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_dm_we", 32'(bus.dm_we), 32'd0);
        check_eq("midrst_m1_ack", 32'(bus.m1_ack), 32'd0);
        r_req[1] = 1'b0;
        drive();
        model_reset();
        @(posedge clk);
        #1;
        check_eq("midrst_mem", mem[16], old_word);
        check_eq("midrst_m0_rdata", bus.m0_rdata, 32'd0);
        check_eq("midrst_m1_rdata", bus.m1_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(3);

        // Randomised traffic
        repeat (3000) step(0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
